// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 7-segment display driver. Scans DIGITS digits at a
// prescaled rate. The displayed value is captured once per frame so the
// display never shows a torn value. Each digit slot starts with a short
// all-dark gap that suppresses ghosting between neighbouring digits.
module fnd_scan_controller #(
   parameter int DIGITS      = 4,
   parameter int CLK_DIV     = 100000,
   parameter int BLANK_CYC   = 2,
   parameter int SEL_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_En,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_lzb,
   output logic [DIGITS-1:0]     o_select_position,
   output logic [7:0]            o_font,
   output logic                  o_frame_start
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0]     PRE_LAST  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0]     PRE_BLANK = PW'(BLANK_CYC);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACT_LOW != 0) ? '1 : '0;
   localparam logic [7:0]        SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                run_q;            // scan was enabled on the previous cycle
   logic [4*DIGITS-1:0] snap_val_q;
   logic [DIGITS-1:0]   snap_dp_q;
   logic                snap_lzb_q;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]          font_q, font_d;
   logic                frame_q, frame_d;

   logic                tick, load, blank_digit;
   logic [3:0]          nib;
   logic [6:0]          seg;
   logic [7:0]          raw;
   logic [DIGITS-1:0]   zero_from;        // bit k: nibbles DIGITS-1..k are all zero
   logic [DIGITS-1:0]   onehot;

   // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   // Leading-zero detection over the snapshot, scanning down from the top digit.
   always_comb begin
      zero_from = '0;
      zero_from[DIGITS-1] = (snap_val_q[4*(DIGITS-1) +: 4] == 4'h0);
      for (int k = DIGITS - 2; k >= 0; k--)
         zero_from[k] = zero_from[k+1] && (snap_val_q[4*k +: 4] == 4'h0);
   end

   // Scan counters, snapshot trigger and the next registered output values.
   always_comb begin
      tick        = (pre_q == PRE_LAST);
      load        = i_En && (!run_q || (tick && idx_q == IDX_LAST));
      pre_d       = '0;
      idx_d       = '0;
      if (i_En) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         idx_d = !tick ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      nib         = snap_val_q[4*int'(idx_q) +: 4];
      blank_digit = snap_lzb_q && (idx_q != '0) && zero_from[idx_q];
      seg         = blank_digit ? 7'h00 : seg7(nib);
      raw         = {snap_dp_q[idx_q], seg};
      onehot      = DIGITS'(1) << idx_q;
      sel_d       = SEL_OFF;
      font_d      = SEG_OFF;
      if (i_En && pre_q >= PRE_BLANK) begin
         sel_d  = (SEL_ACT_LOW != 0) ? ~onehot : onehot;
         font_d = (SEG_ACT_LOW != 0) ? ~raw : raw;
      end
      frame_d     = load;
   end

   // State, snapshot and output registers; reset forces the display dark.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pre_q      <= '0;
         idx_q      <= '0;
         run_q      <= 1'b0;
         snap_val_q <= '0;
         snap_dp_q  <= '0;
         snap_lzb_q <= 1'b0;
         sel_q      <= SEL_OFF;
         font_q     <= SEG_OFF;
         frame_q    <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         run_q      <= i_En;
         if (load) begin
            snap_val_q <= i_value;
            snap_dp_q  <= i_dp;
            snap_lzb_q <= i_lzb;
         end
         sel_q      <= sel_d;
         font_q     <= font_d;
         frame_q    <= frame_d;
      end
   end

   assign o_select_position = sel_q;
   assign o_font            = font_q;
   assign o_frame_start     = frame_q;

endmodule
